// File: rtl/uart_prog_loader.sv
// ----------------------------------------------------------------------------
// uart_prog_loader
//
// Serial program loader for the minisys 32 CPU. An 8N1 UART receiver feeds a
// frame parser that assembles 32-bit little-endian words and writes them into
// instruction or data memory through a single-word write port. The CPU is
// held in reset for the whole duration of a load.
//
// Frame: 0x5A, target (0 = imem, 1 = dmem), length LSB, length MSB (N words),
//        4*N payload bytes (each word LSB first) [, checksum byte].
//
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over the payload. Without it the load completes right after
// the last word is written.
//
// Parameters:
//   CLK_FREQ    clock frequency in Hz
//   BAUD        UART bit rate (bit period = CLK_FREQ/BAUD clocks)
//   ADDR_WIDTH  word-address width of the memory write port
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   uart_rx     serial input, asynchronous, idle high
//   prog_we     one-cycle word write strobe
//   prog_sel    write target: 0 = instruction memory, 1 = data memory
//   prog_addr   word address of the current write
//   prog_wdata  word being written
//   cpu_hold    high while a load is in progress (drives CPU reset)
//   done        sticky: last load completed successfully
//   err         sticky: last load aborted
// ----------------------------------------------------------------------------
module uart_prog_loader #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    output logic                  prog_we,
    output logic                  prog_sel,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic [31:0]           prog_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((HALF > 0) ? (HALF - 1) : 0);

    // ------------------------------------------------------------------------
    // RX front end
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t        rx_state;
    rx_state_t        rx_next;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_half_tick;
    logic             rx_bit_tick;
    logic             rx_stop_tick;

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             frame_err;

    // Two-flop synchronizer plus one extra stage for falling-edge detection.
    // All stages reset high so the idle line never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    // A start bit that is high again at its midpoint is a glitch, not a byte.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_half_tick) begin
                    rx_next = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_bit_tick && (rx_bit == 3'd7)) begin
                    rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_stop_tick) begin
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_half_tick = (rx_state == RX_START) && (rx_cnt == CNT_HALF);
        rx_bit_tick  = (rx_state == RX_DATA)  && (rx_cnt == CNT_FULL);
        rx_stop_tick = (rx_state == RX_STOP)  && (rx_cnt == CNT_FULL);
    end

    // The bit counter restarts at the start-bit midpoint, so every later
    // full-period wrap lands in the middle of a data or stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_cnt     <= '0;
            rx_bit     <= 3'd0;
            rx_shift   <= 8'h00;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (rx_state == RX_IDLE || rx_half_tick || rx_cnt == CNT_FULL) begin
                rx_cnt <= '0;
            end else begin
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
            if (rx_state == RX_START) begin
                rx_bit <= 3'd0;
            end
            if (rx_bit_tick) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
            if (rx_stop_tick) begin
                if (rx_sync) begin
                    byte_valid <= 1'b1;
                    byte_data  <= rx_shift;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TARGET,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_PAYLOAD = ST_CSUM;
    logic [7:0] csum;
`else
    localparam state_t AFTER_PAYLOAD = ST_DONE;
`endif

    state_t      state;
    state_t      state_next;
    logic [7:0]  len_lo;
    logic [15:0] words_left;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;

    logic sync_hit;
    logic data_byte;
    logic word_complete;
    logic payload_end;
    logic len_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A framing error anywhere inside a frame aborts it; in IDLE it is noise.
    // Payload completion is detected on the write cycle itself, so the exit
    // happens one cycle after the final prog_we.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (sync_hit) begin
                    state_next = ST_TARGET;
                end
            end
            ST_TARGET: begin
                if (frame_err) begin
                    state_next = ST_ERR;
                end else if (byte_valid) begin
                    state_next = (byte_data[7:1] == 7'd0) ? ST_LEN0 : ST_ERR;
                end
            end
            ST_LEN0: begin
                if (frame_err) begin
                    state_next = ST_ERR;
                end else if (byte_valid) begin
                    state_next = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (frame_err) begin
                    state_next = ST_ERR;
                end else if (byte_valid) begin
                    state_next = len_zero ? AFTER_PAYLOAD : ST_DATA;
                end
            end
            ST_DATA: begin
                if (frame_err) begin
                    state_next = ST_ERR;
                end else if (payload_end) begin
                    state_next = AFTER_PAYLOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (frame_err) begin
                    state_next = ST_ERR;
                end else if (byte_valid) begin
                    state_next = (byte_data == csum) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sync_hit      = (state == ST_IDLE) && byte_valid && (byte_data == 8'h5A);
        data_byte     = (state == ST_DATA) && byte_valid;
        word_complete = data_byte && (byte_idx == 2'd3);
        payload_end   = (state == ST_DATA) && prog_we && (words_left == 16'd0);
        len_zero      = ({byte_data, len_lo} == 16'd0);
    end

    // prog_addr advances the cycle after each strobe so address and data are
    // both stable while prog_we is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prog_we    <= 1'b0;
            prog_sel   <= 1'b0;
            prog_addr  <= '0;
            prog_wdata <= 32'h0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            len_lo     <= 8'h00;
            words_left <= 16'd0;
            byte_idx   <= 2'd0;
            word_buf   <= 24'h0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= 8'h00;
`endif
        end else begin
            prog_we <= 1'b0;
            if (prog_we) begin
                prog_addr <= prog_addr + ADDR_WIDTH'(1);
            end
            if (sync_hit) begin
                cpu_hold  <= 1'b1;
                done      <= 1'b0;
                err       <= 1'b0;
                prog_addr <= '0;
                byte_idx  <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                csum      <= 8'h00;
`endif
            end
            if (state == ST_TARGET && byte_valid && byte_data[7:1] == 7'd0) begin
                prog_sel <= byte_data[0];
            end
            if (state == ST_LEN0 && byte_valid) begin
                len_lo <= byte_data;
            end
            if (state == ST_LEN1 && byte_valid) begin
                words_left <= {byte_data, len_lo};
            end
            if (data_byte) begin
                byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum     <= csum ^ byte_data;
`endif
                case (byte_idx)
                    2'd0:    word_buf[7:0]   <= byte_data;
                    2'd1:    word_buf[15:8]  <= byte_data;
                    2'd2:    word_buf[23:16] <= byte_data;
                    default: word_buf        <= word_buf;
                endcase
            end
            if (word_complete) begin
                prog_wdata <= {byte_data, word_buf};
                prog_we    <= 1'b1;
                words_left <= words_left - 16'd1;
            end
            if (state == ST_DONE) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
            if (state == ST_ERR) begin
                err      <= 1'b1;
                cpu_hold <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// ----------------------------------------------------------------------------
// tb_uart_prog_loader
//
// Drives whole frames onto uart_rx and compares the loader's memory writes
// and status flags against a frame-level reference model. Writes predicted by
// the model are queued; a monitor pops and compares one entry for every
// prog_we cycle. Works with or without LOADER_CHECKSUM_EN defined.
// A small bit period keeps each byte short.
// ----------------------------------------------------------------------------
module tb_uart_prog_loader;

    localparam int CLK_FREQ   = 2000000;
    localparam int BAUD       = 100000;
    localparam int ADDR_WIDTH = 4;
    localparam int DIV        = CLK_FREQ / BAUD;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  uart_rx = 1'b1;
    logic                  prog_we;
    logic                  prog_sel;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [31:0]           prog_wdata;
    logic                  cpu_hold;
    logic                  done;
    logic                  err;

    uart_prog_loader #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .prog_we    (prog_we),
        .prog_sel   (prog_sel),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                  sel;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
    } wr_t;

    wr_t        expWrites[$];
    logic [7:0] frameBytes[$];
    int         badStopIdx = -1;
    logic       expDone;
    logic       expErr;
    int         holdCount = 0;
    int         checks = 0;
    int         passes = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest prediction.
    always @(negedge clk) begin
        if (rst) begin
            if (cpu_hold) begin
                holdCount++;
            end
            if (prog_we) begin
                if (expWrites.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_write: got sel=%0d addr=%0d data=0x%08h, expected no write",
                             prog_sel, prog_addr, prog_wdata);
                end else begin
                    wr_t e;
                    e = expWrites.pop_front();
                    checkOutput("write", 64'({prog_sel, prog_addr, prog_wdata}), 64'(e));
                end
            end
        end
    end

    task automatic waitClocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 byte followed by one idle bit; optionally a low stop bit.
    task automatic sendByte(input logic [7:0] b, input logic badStop);
        uart_rx = 1'b0;
        waitClocks(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            waitClocks(DIV);
        end
        uart_rx = !badStop;
        waitClocks(DIV);
        uart_rx = 1'b1;
        waitClocks(DIV);
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < frameBytes.size(); i++) begin
            sendByte(frameBytes[i], i == badStopIdx);
        end
    endtask

    // Reference model: parse the byte list as a frame, predict every memory
    // write and the final done/err outcome.
    task automatic modelFrame();
        int         n;
        int         p;
        logic       sel;
        logic [7:0] x;
        logic [31:0] word;
        expDone = 1'b0;
        expErr  = 1'b0;
        if (badStopIdx == 1 || frameBytes[1] > 8'd1) begin
            expErr = 1'b1;
            return;
        end
        if (badStopIdx == 2 || badStopIdx == 3) begin
            expErr = 1'b1;
            return;
        end
        sel = frameBytes[1][0];
        n   = int'(frameBytes[2]) + 256 * int'(frameBytes[3]);
        x   = 8'h00;
        for (int w = 0; w < n; w++) begin
            word = 32'h0;
            for (int k = 0; k < 4; k++) begin
                p = 4 + 4 * w + k;
                if (p == badStopIdx) begin
                    expErr = 1'b1;
                    return;
                end
                word = word | (32'(frameBytes[p]) << (8 * k));
                x    = x ^ frameBytes[p];
            end
            expWrites.push_back({sel, ADDR_WIDTH'(w % (1 << ADDR_WIDTH)), word});
        end
`ifdef LOADER_CHECKSUM_EN
        p = 4 + 4 * n;
        if (p == badStopIdx || frameBytes[p] != x) begin
            expErr = 1'b1;
        end else begin
            expDone = 1'b1;
        end
`else
        expDone = 1'b1;
`endif
    endtask

    task automatic runFrame(input string name);
        int h0;
        modelFrame();
        h0 = holdCount;
        applyStimulus();
        waitClocks(DIV);
        checkOutput({name, "_done"}, 64'(done), 64'(expDone));
        checkOutput({name, "_err"}, 64'(err), 64'(expErr));
        checkOutput({name, "_hold_released"}, 64'(cpu_hold), 64'(0));
        checkOutput({name, "_hold_seen"}, 64'(holdCount > h0), 64'(1));
        checkOutput({name, "_writes_drained"}, 64'(expWrites.size()), 64'(0));
        badStopIdx = -1;
    endtask

    task automatic buildRandomFrame(input logic sel, input int n, input logic force5a);
        logic [7:0] b;
        logic [7:0] x;
        x = 8'h00;
        frameBytes = '{8'h5A};
        frameBytes.push_back({7'd0, sel});
        frameBytes.push_back(8'(n));
        frameBytes.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (force5a && i == 1) begin
                b = 8'h5A;
            end
            frameBytes.push_back(b);
            x = x ^ b;
        end
`ifdef LOADER_CHECKSUM_EN
        frameBytes.push_back(x);
`endif
    endtask

    initial begin : main
        logic [7:0] wrapX;

        // Reset values, during and after reset.
        waitClocks(3);
        checkOutput("reset_outputs", 64'({prog_we, prog_sel, prog_addr, prog_wdata, cpu_hold, done, err}), 64'(0));
        rst = 1'b1;
        waitClocks(5);
        checkOutput("idle_outputs", 64'({prog_we, prog_sel, prog_addr, prog_wdata, cpu_hold, done, err}), 64'(0));

        // Two-word frame into imem; trailing byte is the true payload XOR (0x2A).
        frameBytes = '{8'h5A, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                       8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        runFrame("frame_good");

        // Same frame with a wrong checksum byte.
        frameBytes = '{8'h5A, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                       8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01};
        runFrame("frame_badcsum");

        // Illegal target byte.
        frameBytes = '{8'h5A, 8'h07};
        runFrame("bad_target");

        // Framing error on the third payload byte.
        frameBytes = '{8'h5A, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        badStopIdx = 6;
        runFrame("framing_err");

        // Short low glitch must be rejected; the following frame is clean.
        uart_rx = 1'b0;
        waitClocks(DIV / 2 - 4);
        uart_rx = 1'b1;
        waitClocks(2 * DIV);
        checkOutput("glitch_no_hold", 64'(cpu_hold), 64'(0));
        frameBytes = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
        runFrame("after_glitch");

        // Reset in the middle of DATA, then a full reload from address 0.
        frameBytes = '{8'h5A, 8'h01, 8'h02, 8'h00, 8'h11, 8'h22};
        applyStimulus();
        checkOutput("hold_mid_load", 64'(cpu_hold), 64'(1));
        @(posedge clk);
        #2 rst = 1'b0;
        #1 checkOutput("async_reset_clear",
                       64'({prog_we, prog_sel, prog_addr, prog_wdata, cpu_hold, done, err}), 64'(0));
        @(posedge clk);
        #2 rst = 1'b1;
        waitClocks(DIV);
        frameBytes = '{8'h5A, 8'h01, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                       8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        runFrame("after_reset");

        // Random frames; the second one carries 0x5A inside its payload.
        for (int f = 0; f < 4; f++) begin
            buildRandomFrame(1'($urandom_range(0, 1)), $urandom_range(1, 3), f == 1);
            runFrame($sformatf("random%0d", f));
        end

        // Address wrap: more words than the address space holds.
        buildRandomFrame(1'b1, (1 << ADDR_WIDTH) + 1, 1'b0);
        runFrame("addr_wrap");

        // Wrong checksum on a multi-word dmem frame: writes still land.
        buildRandomFrame(1'b1, 2, 1'b0);
        wrapX = frameBytes[frameBytes.size() - 1];
`ifdef LOADER_CHECKSUM_EN
        frameBytes[frameBytes.size() - 1] = ~wrapX;
`endif
        runFrame("random_badcsum");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
